// File: rtl/i2c_slave_mem_bank_pkg.sv
// Shared definitions for the multi-address I2C slave register bank.
package i2c_slave_mem_bank_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WRITE  = 2'd1,
      ST_READ   = 2'd2,
      ST_IGNORE = 2'd3
   } state_e;

   // Index width for n entries; never narrower than one bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/i2c_slave_mem_bank_addr_match.sv
// Parallel slave-address compare with lowest-index-wins priority encode.
module i2c_addr_match
   import i2c_slave_mem_bank_pkg::*;
#(
   parameter int unsigned ADDRESSLENGTH = 7,
   parameter int unsigned ADDRESSNUM    = 4,
   localparam int unsigned IW           = clog2_min1(ADDRESSNUM)
) (
   input  logic [ADDRESSLENGTH*ADDRESSNUM-1:0] addr_list,
   input  logic [ADDRESSLENGTH-1:0]            addr,
   output logic                                hit_c,
   output logic [IW-1:0]                       idx_c
);

   // Scan from the top so the lowest matching entry is the last to overwrite.
   always_comb begin
      hit_c = 1'b0;
      idx_c = '0;
      for (int i = int'(ADDRESSNUM) - 1; i >= 0; i--) begin
         if (addr_list[ADDRESSLENGTH*i +: ADDRESSLENGTH] == addr) begin
            hit_c = 1'b1;
            idx_c = IW'(i);
         end
      end
   end

endmodule

// File: rtl/i2c_slave_mem_bank.sv
// I2C slave register memory: one byte bank per slave address, auto-increment
// pointer, read/write handshakes and a user-side combinational read port.
module i2c_slave_mem_bank
   import i2c_slave_mem_bank_pkg::*;
#(
   parameter int unsigned ADDRESSLENGTH = 7,
   parameter int unsigned ADDRESSNUM    = 4,
   parameter int unsigned NBYTES        = 4,
   parameter int unsigned WRAP          = 1,
   localparam int unsigned BW           = clog2_min1(ADDRESSNUM),
   localparam int unsigned PW           = clog2_min1(NBYTES)
) (
   input  logic                                Clk,
   input  logic                                Reset,
   input  logic [ADDRESSLENGTH*ADDRESSNUM-1:0] AddressList,
   input  logic                                AddrValid,
   input  logic [ADDRESSLENGTH-1:0]            Addr,
   input  logic                                RorW,
   input  logic                                WrValid,
   input  logic [BYTE_W-1:0]                   WrData,
   input  logic                                RdReq,
   input  logic                                Stop,
   output logic [BYTE_W-1:0]                   RdData,
   output logic                                RdValid,
   output logic                                Ack,
   output logic                                AddressFound,
   output logic [BW-1:0]                       BankSel,
   output logic                                Overflow,
   input  logic [BW-1:0]                       UserBank,
   input  logic [PW-1:0]                       UserByte,
   output logic [BYTE_W-1:0]                   UserData
);

   state_e              state_q, state_d;
   logic [PW-1:0]       ptr_q, ptr_d;
   logic [BYTE_W-1:0]   rd_data_q, rd_data_d;
   logic                rd_valid_q, rd_valid_d;
   logic                ack_q, ack_d;
   logic                found_q, found_d;
   logic [BW-1:0]       bank_q, bank_d;
   logic                ovf_q, ovf_d;
   logic                mem_we_c;
   logic                adv_c;
   logic                hit_c;
   logic [BW-1:0]       idx_c;
   logic [BYTE_W-1:0]   mem [ADDRESSNUM][NBYTES];

   i2c_addr_match #(
      .ADDRESSLENGTH (ADDRESSLENGTH),
      .ADDRESSNUM    (ADDRESSNUM)
   ) u_addr_match (
      .addr_list (AddressList),
      .addr      (Addr),
      .hit_c     (hit_c),
      .idx_c     (idx_c)
   );

   // Next-state and output decode; a new address always takes priority.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      ack_d      = 1'b0;
      found_d    = found_q;
      bank_d     = bank_q;
      ovf_d      = ovf_q;
      mem_we_c   = 1'b0;
      adv_c      = 1'b0;

      if (AddrValid) begin
         ovf_d = 1'b0;
         if (hit_c) begin
            found_d = 1'b1;
            bank_d  = idx_c;
            ack_d   = 1'b1;
            ptr_d   = '0;
            state_d = RorW ? ST_READ : ST_WRITE;
         end else begin
            found_d = 1'b0;
            state_d = ST_IGNORE;
         end
      end else begin
         case (state_q)
            ST_WRITE: begin
               if (WrValid) begin
                  mem_we_c = 1'b1;
                  ack_d    = 1'b1;
                  adv_c    = 1'b1;
               end
            end
            ST_READ: begin
               if (RdReq) begin
                  rd_data_d  = mem[bank_q][ptr_q];
                  rd_valid_d = 1'b1;
                  adv_c      = 1'b1;
               end
            end
            default: ;
         endcase

         // At the last byte the pointer either wraps or parks and flags overflow.
         if (adv_c) begin
            if (ptr_q == PW'(NBYTES - 1)) begin
               if (WRAP != 0) ptr_d = '0;
               else           ovf_d = 1'b1;
            end else begin
               ptr_d = ptr_q + PW'(1);
            end
         end

         if (Stop) begin
            state_d = ST_IDLE;
            found_d = 1'b0;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         ack_q      <= 1'b0;
         found_q    <= 1'b0;
         bank_q     <= '0;
         ovf_q      <= 1'b0;
         mem        <= '{default: '0};
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         ack_q      <= ack_d;
         found_q    <= found_d;
         bank_q     <= bank_d;
         ovf_q      <= ovf_d;
         if (mem_we_c) mem[bank_q][ptr_q] <= WrData;
      end
   end

   assign RdData       = rd_data_q;
   assign RdValid      = rd_valid_q;
   assign Ack          = ack_q;
   assign AddressFound = found_q;
   assign BankSel      = bank_q;
   assign Overflow     = ovf_q;
   assign UserData     = mem[UserBank][UserByte];

endmodule

// File: tb/tb_i2c_slave_mem_bank.sv
// Directed bench: a wrapping and a saturating instance share one stimulus stream.
module tb_i2c_slave_mem_bank;

   logic        Clk;
   logic        Reset;
   logic [27:0] AddressList;
   logic        AddrValid;
   logic [6:0]  Addr;
   logic        RorW;
   logic        WrValid;
   logic [7:0]  WrData;
   logic        RdReq;
   logic        Stop;
   logic [1:0]  UserBank;
   logic [1:0]  UserByte;

   logic [7:0]  w_rd_data, s_rd_data;
   logic        w_rd_valid, s_rd_valid;
   logic        w_ack, s_ack;
   logic        w_found, s_found;
   logic [1:0]  w_bank, s_bank;
   logic        w_ovf, s_ovf;
   logic [7:0]  w_user, s_user;

   int errors = 0;
   int checks = 0;

   i2c_slave_mem_bank #(.ADDRESSLENGTH(7), .ADDRESSNUM(4), .NBYTES(4), .WRAP(1)) u_dut_wrap (
      .Clk(Clk), .Reset(Reset), .AddressList(AddressList), .AddrValid(AddrValid),
      .Addr(Addr), .RorW(RorW), .WrValid(WrValid), .WrData(WrData), .RdReq(RdReq),
      .Stop(Stop), .RdData(w_rd_data), .RdValid(w_rd_valid), .Ack(w_ack),
      .AddressFound(w_found), .BankSel(w_bank), .Overflow(w_ovf),
      .UserBank(UserBank), .UserByte(UserByte), .UserData(w_user)
   );

   i2c_slave_mem_bank #(.ADDRESSLENGTH(7), .ADDRESSNUM(4), .NBYTES(4), .WRAP(0)) u_dut_sat (
      .Clk(Clk), .Reset(Reset), .AddressList(AddressList), .AddrValid(AddrValid),
      .Addr(Addr), .RorW(RorW), .WrValid(WrValid), .WrData(WrData), .RdReq(RdReq),
      .Stop(Stop), .RdData(s_rd_data), .RdValid(s_rd_valid), .Ack(s_ack),
      .AddressFound(s_found), .BankSel(s_bank), .Overflow(s_ovf),
      .UserBank(UserBank), .UserByte(UserByte), .UserData(s_user)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Each stimulus is applied for exactly one rising edge, then outputs are sampled.
   task automatic cyc();
      @(negedge Clk);
   endtask

   task automatic start(input logic [6:0] a, input logic rw);
      Addr = a; RorW = rw; AddrValid = 1'b1;
      cyc();
      AddrValid = 1'b0;
   endtask

   task automatic wr(input logic [7:0] d);
      WrData = d; WrValid = 1'b1;
      cyc();
      WrValid = 1'b0;
   endtask

   task automatic rd();
      RdReq = 1'b1;
      cyc();
      RdReq = 1'b0;
   endtask

   task automatic stop();
      Stop = 1'b1;
      cyc();
      Stop = 1'b0;
   endtask

   task automatic peek(input logic [1:0] b, input logic [1:0] y);
      UserBank = b; UserByte = y;
      #1;
   endtask

   initial begin
      Reset = 1'b1; AddrValid = 1'b0; Addr = '0; RorW = 1'b0; WrValid = 1'b0;
      WrData = '0; RdReq = 1'b0; Stop = 1'b0; UserBank = '0; UserByte = '0;
      AddressList = {7'h23, 7'h22, 7'h21, 7'h20};
      repeat (3) cyc();
      Reset = 1'b0;
      cyc();

      // Reset state
      check("rst_rddata", 32'(w_rd_data), 32'h00);
      check("rst_rdvalid", 32'(w_rd_valid), 32'd0);
      check("rst_ack", 32'(w_ack), 32'd0);
      check("rst_found", 32'(w_found), 32'd0);
      check("rst_banksel", 32'(w_bank), 32'd0);
      check("rst_ovf", 32'(w_ovf), 32'd0);
      peek(2'd3, 2'd3);
      check("rst_mem33", 32'(w_user), 32'h00);

      // Match on the third list entry
      start(7'h22, 1'b0);
      check("m22_ack", 32'(w_ack), 32'd1);
      check("m22_found", 32'(w_found), 32'd1);
      check("m22_bank", 32'(w_bank), 32'd2);
      cyc();
      check("m22_ack_pulse", 32'(w_ack), 32'd0);
      stop();
      check("stop_found", 32'(w_found), 32'd0);

      // Write A1, B2 to 0x21 then read them back
      start(7'h21, 1'b0);
      check("m21_bank", 32'(w_bank), 32'd1);
      wr(8'hA1);
      check("wr_a1_ack", 32'(w_ack), 32'd1);
      peek(2'd1, 2'd0);
      check("user_b1_0", 32'(w_user), 32'hA1);
      wr(8'hB2);
      check("wr_b2_ack", 32'(w_ack), 32'd1);
      stop();
      start(7'h21, 1'b1);
      check("rd21_ack", 32'(w_ack), 32'd1);
      rd();
      check("rd0_valid", 32'(w_rd_valid), 32'd1);
      check("rd0_data", 32'(w_rd_data), 32'hA1);
      cyc();
      check("rd0_valid_pulse", 32'(w_rd_valid), 32'd0);
      rd();
      check("rd1_valid", 32'(w_rd_valid), 32'd1);
      check("rd1_data", 32'(w_rd_data), 32'hB2);
      stop();

      // Unknown address: everything ignored
      start(7'h55, 1'b0);
      check("nomatch_found", 32'(w_found), 32'd0);
      check("nomatch_ack", 32'(w_ack), 32'd0);
      for (int i = 0; i < 3; i++) begin
         wr(8'hFF);
         check("ign_ack", 32'(w_ack), 32'd0);
      end
      peek(2'd0, 2'd0); check("ign_b0", 32'(w_user), 32'h00);
      peek(2'd1, 2'd0); check("ign_b1_0", 32'(w_user), 32'hA1);
      peek(2'd1, 2'd1); check("ign_b1_1", 32'(w_user), 32'hB2);
      peek(2'd2, 2'd0); check("ign_b2", 32'(w_user), 32'h00);
      peek(2'd3, 2'd0); check("ign_b3", 32'(w_user), 32'h00);
      stop();

      // Five writes into a four-byte bank: wrap vs saturate
      start(7'h20, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         wr(8'(i));
         check("wr5_ack_sat", 32'(s_ack), 32'd1);
      end
      check("wrap_ovf", 32'(w_ovf), 32'd0);
      check("sat_ovf", 32'(s_ovf), 32'd1);
      peek(2'd0, 2'd0); check("wrap_b0", 32'(w_user), 32'h05); check("sat_b0", 32'(s_user), 32'h01);
      peek(2'd0, 2'd1); check("wrap_b1", 32'(w_user), 32'h02); check("sat_b1", 32'(s_user), 32'h02);
      peek(2'd0, 2'd2); check("wrap_b2", 32'(w_user), 32'h03); check("sat_b2", 32'(s_user), 32'h03);
      peek(2'd0, 2'd3); check("wrap_b3", 32'(w_user), 32'h04); check("sat_b3", 32'(s_user), 32'h05);
      start(7'h20, 1'b0);
      check("sat_ovf_clr", 32'(s_ovf), 32'd0);
      stop();

      // Duplicate entries: lowest index wins; repeated start resets pointer
      AddressList = {7'h23, 7'h22, 7'h30, 7'h30};
      start(7'h30, 1'b0);
      check("dup_bank", 32'(w_bank), 32'd0);
      wr(8'h11);
      wr(8'h22);
      start(7'h30, 1'b0);
      check("rs_ack", 32'(w_ack), 32'd1);
      wr(8'h33);
      peek(2'd0, 2'd0); check("rs_b0", 32'(w_user), 32'h33);
      peek(2'd0, 2'd1); check("rs_b1", 32'(w_user), 32'h22);

      // Stop coincident with a write: byte lands, then idle
      WrData = 8'h44; WrValid = 1'b1; Stop = 1'b1;
      cyc();
      WrValid = 1'b0; Stop = 1'b0;
      check("stopwr_ack", 32'(w_ack), 32'd1);
      check("stopwr_found", 32'(w_found), 32'd0);
      peek(2'd0, 2'd1); check("stopwr_b1", 32'(w_user), 32'h44);
      wr(8'h55);
      check("idle_wr_ack", 32'(w_ack), 32'd0);
      peek(2'd0, 2'd2); check("idle_wr_b2", 32'(w_user), 32'h03);

      // AddrValid coincident with a write: data discarded
      Addr = 7'h30; RorW = 1'b0; AddrValid = 1'b1; WrData = 8'h66; WrValid = 1'b1;
      cyc();
      AddrValid = 1'b0; WrValid = 1'b0;
      check("avwr_ack", 32'(w_ack), 32'd1);
      peek(2'd0, 2'd0); check("avwr_b0", 32'(w_user), 32'h33);
      wr(8'h77);
      peek(2'd0, 2'd0); check("avwr_next_b0", 32'(w_user), 32'h77);

      // Reset mid-write clears everything and suppresses the ack
      WrData = 8'h99; WrValid = 1'b1; Reset = 1'b1;
      cyc();
      WrValid = 1'b0; Reset = 1'b0;
      check("rstmid_ack", 32'(w_ack), 32'd0);
      check("rstmid_found", 32'(w_found), 32'd0);
      check("rstmid_bank", 32'(w_bank), 32'd0);
      check("rstmid_rdvalid", 32'(w_rd_valid), 32'd0);
      peek(2'd0, 2'd0); check("rstmid_b0", 32'(w_user), 32'h00);
      peek(2'd1, 2'd0); check("rstmid_b1", 32'(w_user), 32'h00);

      // AddrValid coincident with Stop: new transfer wins
      Addr = 7'h22; RorW = 1'b1; AddrValid = 1'b1; Stop = 1'b1;
      cyc();
      AddrValid = 1'b0; Stop = 1'b0;
      check("avstop_found", 32'(w_found), 32'd1);
      check("avstop_bank", 32'(w_bank), 32'd2);
      rd();
      check("avstop_rdvalid", 32'(w_rd_valid), 32'd1);
      check("avstop_rddata", 32'(w_rd_data), 32'h00);
      stop();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
